// File: rtl/seq_sched_pkg.sv
// Shared constants for the time-shared serial pattern detector.
package seq_sched_pkg;

  localparam int NCH_DEF    = 4;
  localparam int MAXLEN_DEF = 8;

  localparam int CH_W  = $clog2(NCH_DEF);
  localparam int LEN_W = $clog2(MAXLEN_DEF + 1);

  // Power-on pattern: 10101, five bits long.
  localparam logic [7:0] DEF_PAT = 8'b0001_0101;
  localparam int         DEF_LEN = 5;

endpackage

// File: rtl/seq_match_core.sv
// Combinational shift-and-compare step for one serial bit.
// A single copy is shared by all channels through the grant mux.
module seq_match_core #(
  parameter int MAXLEN = 8,
  parameter int LEN_W  = 4
) (
  input  logic [MAXLEN-1:0] hist,
  input  logic [LEN_W-1:0]  fill,
  input  logic              din,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [LEN_W-1:0]  len,
  output logic [MAXLEN-1:0] hist_next,
  output logic [LEN_W-1:0]  fill_next,
  output logic              match
);

  logic [MAXLEN-1:0] mask;

  always_comb begin
    hist_next = {hist[MAXLEN-2:0], din};
    fill_next = (fill >= LEN_W'(MAXLEN)) ? LEN_W'(MAXLEN) : fill + 1'b1;

    // Only the most recent len bits take part in the comparison.
    mask = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      mask[i] = (i < int'(len));
    end

    match = (((hist_next ^ pattern) & mask) == '0) &&
            (fill_next >= len) && (len != '0);
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one pattern-match core across NCH serial
// channels, with per-channel history and saturating match counters.
module seq_detect_sched
  import seq_sched_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int MAXLEN = 8,
  parameter int CNTW   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       cfg_wr,
  input  logic [MAXLEN-1:0]          cfg_pat,
  input  logic [$clog2(MAXLEN+1)-1:0] cfg_len,
  output logic                       cfg_err,
  input  logic [NCH-1:0]             ch_valid,
  input  logic [NCH-1:0]             ch_bit,
  output logic [NCH-1:0]             ch_ready,
  input  logic                       cnt_clr,
  output logic                       match_valid,
  output logic [$clog2(NCH)-1:0]     match_ch,
  output logic [NCH*CNTW-1:0]        match_cnt
);

  localparam int CW = $clog2(NCH);
  localparam int LW = $clog2(MAXLEN + 1);

  logic [MAXLEN-1:0] hist_reg [NCH];
  logic [LW-1:0]     fill_reg [NCH];
  logic [CNTW-1:0]   cnt_reg  [NCH];
  logic [CW-1:0]     ptr_reg;
  logic [MAXLEN-1:0] pat_reg;
  logic [LW-1:0]     len_reg;

  logic [CW-1:0]     grant;
  logic              found;
  logic              active;
  logic              xfer;
  logic              cfg_ok;
  logic [MAXLEN-1:0] hist_n;
  logic [LW-1:0]     fill_n;
  logic              match;

  // First valid channel at or after ptr, wrapping past NCH-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && ch_valid[(int'(ptr_reg) + k) % NCH]) begin
        found = 1'b1;
        grant = CW'((int'(ptr_reg) + k) % NCH);
      end
    end
  end

  assign active   = en & ~cfg_wr & ~rst;
  assign xfer     = active & found;
  assign ch_ready = xfer ? (NCH'(1) << grant) : '0;
  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LW'(MAXLEN));

  seq_match_core #(
    .MAXLEN (MAXLEN),
    .LEN_W  (LW)
  ) u_core (
    .hist      (hist_reg[grant]),
    .fill      (fill_reg[grant]),
    .din       (ch_bit[grant]),
    .pattern   (pat_reg),
    .len       (len_reg),
    .hist_next (hist_n),
    .fill_next (fill_n),
    .match     (match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg     <= '0;
      pat_reg     <= MAXLEN'(DEF_PAT);
      len_reg     <= LW'(DEF_LEN);
      match_valid <= 1'b0;
      match_ch    <= '0;
      cfg_err     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        hist_reg[i] <= '0;
        fill_reg[i] <= '0;
        cnt_reg[i]  <= '0;
      end
    end else begin
      match_valid <= xfer & match;
      cfg_err     <= cfg_wr & ~cfg_ok;
      if (xfer && match) begin
        match_ch <= grant;
      end
      if (xfer) begin
        ptr_reg <= (grant == CW'(NCH - 1)) ? '0 : grant + 1'b1;
      end

      // A new pattern invalidates every partial match in flight.
      if (cfg_wr && cfg_ok) begin
        pat_reg <= cfg_pat;
        len_reg <= cfg_len;
        for (int i = 0; i < NCH; i++) begin
          hist_reg[i] <= '0;
          fill_reg[i] <= '0;
        end
      end else if (xfer) begin
        hist_reg[grant] <= hist_n;
        fill_reg[grant] <= fill_n;
      end

      for (int i = 0; i < NCH; i++) begin
        if (cnt_clr) begin
          cnt_reg[i] <= '0;
        end else if (xfer && match && (grant == CW'(i)) && (cnt_reg[i] != '1)) begin
          cnt_reg[i] <= cnt_reg[i] + 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt_out
    assign match_cnt[gi*CNTW +: CNTW] = cnt_reg[gi];
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench: stimulus pushes expected matches/errors into queues and a
// negedge monitor pops and compares them as the DUT reports.
module tb_seq_detect_sched;

  localparam int NCH    = 4;
  localparam int MAXLEN = 8;
  localparam int CNTW   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_wr;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_err;
  logic [3:0] ch_valid;
  logic [3:0] ch_bit;
  logic [3:0] ch_ready;
  logic       cnt_clr;
  logic       match_valid;
  logic [1:0] match_ch;
  logic [7:0] match_cnt;

  int checks = 0;
  int fails  = 0;
  int exp_match_q[$];
  int err_pending = 0;
  int mon_exp;

  always #5 clk = ~clk;

  seq_detect_sched #(
    .NCH    (NCH),
    .MAXLEN (MAXLEN),
    .CNTW   (CNTW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_wr      (cfg_wr),
    .cfg_pat     (cfg_pat),
    .cfg_len     (cfg_len),
    .cfg_err     (cfg_err),
    .ch_valid    (ch_valid),
    .ch_bit      (ch_bit),
    .ch_ready    (ch_ready),
    .cnt_clr     (cnt_clr),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .match_cnt   (match_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(match_cnt[ch*CNTW +: CNTW]);
  endfunction

  always @(negedge clk) begin
    if (match_valid) begin
      if (exp_match_q.size() == 0) begin
        check("match_unexpected", int'(match_valid), 0);
      end else begin
        mon_exp = exp_match_q.pop_front();
        check("match_ch", int'(match_ch), mon_exp);
      end
    end
    if (cfg_err) begin
      if (err_pending == 0) begin
        check("cfg_err_unexpected", int'(cfg_err), 0);
      end else begin
        err_pending--;
        check("cfg_err", int'(cfg_err), 1);
      end
    end
  end

  // Called just after a rising edge; returns just after the next one.
  task automatic send(input int ch, input logic b, input logic exp);
    ch_valid     = 4'(1 << ch);
    ch_bit       = '0;
    ch_bit[ch]   = b;
    #1;
    check("grant", int'(ch_ready), 1 << ch);
    if (exp) exp_match_q.push_back(ch);
    @(posedge clk);
    #1;
    ch_valid = '0;
    $display("xfer ch=%0d bit=%0d expect_match=%0d", ch, b, exp);
  endtask

  task automatic send_seq(input int ch, input logic [15:0] bits, input int n,
                          input logic [15:0] exp);
    for (int k = n - 1; k >= 0; k--) send(ch, bits[k], exp[k]);
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic bad);
    cfg_wr   = 1'b1;
    cfg_pat  = pat;
    cfg_len  = len;
    ch_valid = 4'hF;
    #1;
    check("cfg_no_grant", int'(ch_ready), 0);
    if (bad) err_pending++;
    @(posedge clk);
    #1;
    cfg_wr   = 1'b0;
    ch_valid = '0;
    $display("cfg pat=%b len=%0d expect_err=%0d", pat, len, bad);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [4:0] bits0;

  initial begin
    rst = 1'b1; en = 1'b1; cfg_wr = 1'b0; cfg_pat = '0; cfg_len = '0;
    ch_valid = 4'hF; ch_bit = '0; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ch_ready", int'(ch_ready), 0);
    check("rst_match_valid", int'(match_valid), 0);
    check("rst_match_ch", int'(match_ch), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_match_cnt", int'(match_cnt), 0);
    rst = 1'b0;
    ch_valid = '0;

    // Default 10101 on ch0: overlapping matches on transfers 5 and 7.
    send_seq(0, 16'b1010101, 7, 16'b0000101);
    check("cnt0_after_stream", cnt_of(0), 2);
    @(posedge clk);
    #1;

    // Round-robin from ptr=0 with every channel requesting.
    pulse_reset();
    en = 1'b0;
    ch_valid = 4'hF;
    ch_bit = '0;
    #1;
    check("en_off_no_grant", int'(ch_ready), 0);
    en = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_grant", int'(ch_ready), 1 << (k % 4));
      $display("rr cycle=%0d ready=%b", k, ch_ready);
      @(posedge clk);
      #1;
    end
    ch_valid = '0;

    // ch0 and ch1 interleaved; only ch0 completes 10101.
    bits0 = 5'b10101;
    for (int k = 0; k < 10; k++) begin
      ch_valid = 4'b0011;
      ch_bit   = '0;
      ch_bit[0] = bits0[4 - k / 2];
      ch_bit[1] = 1'b1;
      #1;
      check("interleave_grant", int'(ch_ready), 1 << (k % 2));
      if ((k % 2 == 0) && (k / 2 == 4)) exp_match_q.push_back(0);
      @(posedge clk);
      #1;
      $display("interleave cycle=%0d ready=%b", k, ch_ready);
    end
    ch_valid = '0;
    check("cnt0_isolation", cnt_of(0), 1);
    check("cnt1_isolation", cnt_of(1), 0);

    // New pattern 110 clears history: 1,1 before cfg must not count.
    send_seq(2, 16'b11, 2, 16'b0);
    do_cfg(8'b0000_0110, 4'd3, 1'b0);
    send_seq(2, 16'b10110, 5, 16'b00001);
    do_cfg(8'b1111_1111, 4'd0, 1'b1);
    do_cfg(8'b1111_1111, 4'd9, 1'b1);
    send_seq(2, 16'b110, 3, 16'b001);
    check("cnt2_after_cfg", cnt_of(2), 2);

    // Counter saturation at 3 for CNTW=2, then clear racing an increment.
    send_seq(3, 16'b110110110110, 12, 16'b001001001001);
    check("cnt3_saturate", cnt_of(3), 3);
    send_seq(3, 16'b11, 2, 16'b0);
    cnt_clr = 1'b1;
    send(3, 1'b0, 1'b1);
    cnt_clr = 1'b0;
    check("cnt3_clr_wins", cnt_of(3), 0);
    check("cnt0_clr", cnt_of(0), 0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-pattern discards the partial 1010.
    pulse_reset();
    send_seq(1, 16'b1010, 4, 16'b0);
    rst = 1'b1;
    #2;
    check("async_rst_cnt", int'(match_cnt), 0);
    rst = 1'b0;
    send(1, 1'b1, 1'b0);
    send_seq(1, 16'b0101, 4, 16'b0001);
    check("cnt1_after_rst", cnt_of(1), 1);

    repeat (3) @(posedge clk);
    #1;
    check("pending_matches", exp_match_q.size(), 0);
    check("pending_cfg_err", err_pending, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
